fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin scheduler that drains eight input FIFOs into a single downstream FIFO.
- Enabled by the link FSM while that FSM is in ACTIVE.
- Issues one-hot pop requests to non-empty input FIFOs, then pushes the returned word downstream one cycle later.
- Stalls new pops when the downstream FIFO reports almost-full.

Parameters:
- DATA_WIDTH, 6, width of each FIFO word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- enable  input  1  1 = arbitration allowed (driven high by the FSM in ACTIVE).
- empty_fifos  input  8  bit i = empty flag of input FIFO i.
- data_in  input  8*DATA_WIDTH  read data of FIFO i on bits [i*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after that FIFO's pop.
- almost_full_out  input  1  downstream FIFO at or above its high threshold.
- pop  output  8  registered one-hot pop strobes; at most one bit set.
- push  output  1  registered downstream write strobe.
- data_out  output  DATA_WIDTH  word written downstream, valid when push=1.
- grant_idx  output  3  index of the FIFO popped in the previous cycle, valid with push.
- state  output  2  arbiter state: IDLE=0, RUN=1, PAUSE=2.
- xfer_count  output  8  number of words pushed, wraps at 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - pop=0, push=0, data_out=0, grant_idx=0, state=IDLE, xfer_count=0.
  - Round-robin pointer rr_ptr=0; in-flight flag clear.
- Eligibility in a cycle: FIFO i is eligible when empty_fifos[i]=0 AND pop[i] was not set in the previous cycle. The FIFO's empty flag lags its pop by one cycle, so a FIFO is never popped two cycles in a row.
- Selection:
  - Take the first eligible index scanning rr_ptr, rr_ptr+1, ..., rr_ptr+7, all mod 8.
  - On a grant to index g, rr_ptr <= g+1 mod 8. 7 wraps to 0.
- Pop issue: pop <= one-hot(g) on the next edge, only when state is RUN (evaluated on the next-state value), almost_full_out=0, enable=1 and at least one FIFO is eligible. Otherwise pop <= 0.
- Push (fixed latency of 1 cycle after pop):
  - Any cycle with pop[g]=1 is followed by push=1, data_out=data_in slice g, grant_idx=g, xfer_count+1.
  - An in-flight push always completes, even if enable drops, almost_full_out rises, or the state changes.
  - data_out and grant_idx hold their last values when push=0.
- States:
  - IDLE:
    - -> RUN when enable=1, almost_full_out=0 and empty_fifos != 8'hFF.
    - Otherwise stays in IDLE.
  - RUN:
    - -> PAUSE when almost_full_out=1.
    - -> IDLE when enable=0, or when all FIFOs are empty and no pop is in flight.
    - Otherwise stays in RUN.
  - PAUSE (no pops issued):
    - -> IDLE when enable=0.
    - -> RUN when almost_full_out=0.
  - Unused encoding 3 -> IDLE.
- Simultaneous events:
  - enable=0 takes priority over almost_full_out.
  - almost_full_out=1 takes priority over issuing a pop in the same cycle.
  - The downstream threshold must leave at least 1 word of slack, because one push can follow the stall.
- Throughput:
  - 1 word/cycle when at least two FIFOs are non-empty.
  - 1 word every 2 cycles when only one FIFO is non-empty.
- rr_ptr is not reset by IDLE or PAUSE; fairness is preserved across stalls.
- Reset asserted mid-transfer drops any in-flight push (push=0 immediately).

Test Plan:
- Reset, then enable=1 with empty_fifos=8'hFF -> state stays IDLE, pop=0, push=0 for 10 cycles.
- FIFOs 0, 3 and 7 non-empty (empty_fifos=8'h76), each holding 2 words -> pop sequence 0x01, 0x08, 0x80, 0x01, 0x08, 0x80; each push one cycle after its pop with the matching data; xfer_count ends at 6; state then returns to IDLE.
- Only FIFO 5 non-empty, holding 3 words -> pop=0x20 on alternating cycles only, 3 pushes, grant_idx=5 each time.
- almost_full_out raised in the same cycle as a pop -> exactly one push follows, state=PAUSE, pop=0 while it is held. On release, the next grant resumes from rr_ptr with no index repeated or skipped.
- enable dropped during RUN with a pop in flight -> that push completes, state=IDLE, no further pops.
- 256 single-FIFO transfers -> xfer_count wraps to 0. Asynchronous reset mid-stream -> all outputs go to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler draining eight input FIFOs into one downstream FIFO.
// Pops are one-hot and registered; the popped word is pushed downstream one cycle later.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              empty_fifos,
    input  logic [8*DATA_WIDTH-1:0] data_in,
    input  logic                    almost_full_out,
    output logic [7:0]              pop,
    output logic                    push,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [2:0]              grant_idx,
    output logic [1:0]              state,
    output logic [7:0]              xfer_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [7:0]              r_pop;
    logic                    r_push;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic [2:0]              r_grant_idx;
    logic [7:0]              r_xfer_count;
    logic [2:0]              r_rr_ptr;
    logic [2:0]              r_pop_idx;
    logic                    r_inflight;

    logic [7:0]              w_eligible;
    logic                    w_any_eligible;
    logic [2:0]              w_grant;
    logic                    w_issue;
    logic                    w_all_empty;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    // Empty flags lag a pop by one cycle, so a FIFO popped last cycle is not eligible.
    assign w_eligible  = ~empty_fifos & ~r_pop;
    assign w_all_empty = (empty_fifos == 8'hFF);

    always_comb begin
        logic [2:0] cand;
        w_grant        = r_rr_ptr;
        w_any_eligible = 1'b0;
        cand           = r_rr_ptr;
        for (int k = 0; k < 8; k++) begin
            cand = r_rr_ptr + 3'(k);
            if (!w_any_eligible && w_eligible[cand]) begin
                w_grant        = cand;
                w_any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = StIdle;
        case (r_state)
            StIdle: begin
                if (enable && !almost_full_out && !w_all_empty) begin
                    w_state_next = StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StRun: begin
                if (!enable) begin
                    w_state_next = StIdle;
                end else if (almost_full_out) begin
                    w_state_next = StPause;
                end else if (w_all_empty && !r_inflight) begin
                    w_state_next = StIdle;
                end else begin
                    w_state_next = StRun;
                end
            end
            StPause: begin
                if (!enable) begin
                    w_state_next = StIdle;
                end else if (!almost_full_out) begin
                    w_state_next = StRun;
                end else begin
                    w_state_next = StPause;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_issue = (w_state_next == StRun) && !almost_full_out && enable && w_any_eligible;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (r_pop_idx == 3'(i)) begin
                w_sel_data = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_pop        <= '0;
            r_push       <= 1'b0;
            r_data_out   <= '0;
            r_grant_idx  <= '0;
            r_xfer_count <= '0;
            r_rr_ptr     <= '0;
            r_pop_idx    <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pop      <= w_issue ? (8'b1 << w_grant) : 8'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pop_idx <= w_grant;
                r_rr_ptr  <= w_grant + 3'd1;
            end
            // An issued pop always completes as a push, regardless of state or stall.
            r_push <= r_inflight;
            if (r_inflight) begin
                r_data_out   <= w_sel_data;
                r_grant_idx  <= r_pop_idx;
                r_xfer_count <= r_xfer_count + 8'd1;
            end
        end
    end

    assign pop        = r_pop;
    assign push       = r_push;
    assign data_out   = r_data_out;
    assign grant_idx  = r_grant_idx;
    assign state      = r_state;
    assign xfer_count = r_xfer_count;

`ifndef SYNTHESIS
    a_pop_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(r_pop));
    a_state_legal : assert property (@(posedge clk) disable iff (!reset) r_state != 2'd3);
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: behavioural input FIFOs, expected pushes queued
// by the stimulus and consumed by a monitor on every downstream push.
module tb_fifo_rr_arbiter;

    localparam int unsigned DW = 6;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic            afo = 1'b0;
    logic [7:0]      empty_fifos;
    logic [8*DW-1:0] data_in;
    logic [7:0]      pop;
    logic            push;
    logic [DW-1:0]   data_out;
    logic [2:0]      grant_idx;
    logic [1:0]      state;
    logic [7:0]      xfer_count;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .empty_fifos     (empty_fifos),
        .data_in         (data_in),
        .almost_full_out (afo),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .grant_idx       (grant_idx),
        .state           (state),
        .xfer_count      (xfer_count)
    );

    typedef struct packed {
        logic [2:0]    idx;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] fq [8][$];
    exp_t          exp_q [$];
    exp_t          mon_e;
    int unsigned   total = 0;
    int unsigned   bad = 0;
    logic [7:0]    exp_cnt = 8'd0;
    logic [7:0]    pop_snap;

    task automatic check(input string name, input int unsigned act, input int unsigned want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < 8; i++) begin
            empty_fifos[i] = (fq[i].size() == 0);
            data_in[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endfunction

    task automatic expect_push(input int idx, input logic [DW-1:0] d);
        exp_t e;
        e.idx  = 3'(idx);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int k = 0; k < max_cycles && state != 2'd0; k++) @(negedge clk);
        check("reach_idle", state, 0);
    endtask

    // Show-ahead input FIFOs: head word is on data_in, popped on the edge where pop is high.
    always @(posedge clk) begin
        pop_snap = pop;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (pop_snap[i]) begin
                check("pop_nonempty", int'(fq[i].size() != 0), 1);
                if (fq[i].size() != 0) void'(fq[i].pop_front());
            end
        end
        refresh();
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_cnt = 8'd0;
        end else if (push) begin
            exp_cnt = exp_cnt + 8'd1;
            check("sb_has_entry", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("grant_idx", grant_idx, mon_e.idx);
                check("data_out", data_out, mon_e.data);
            end
            check("xfer_count", xfer_count, exp_cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq2 [6];
        logic [7:0] seq3 [6];
        logic [7:0] seq4 [4];
        seq2 = '{8'h01, 8'h08, 8'h80, 8'h01, 8'h08, 8'h80};
        seq3 = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00};
        seq4 = '{8'h10, 8'h02, 8'h04, 8'h10};
        refresh();

        // Reset values, then enabled with all FIFOs empty.
        repeat (2) @(negedge clk);
        check("rst_pop", pop, 0);
        check("rst_push", push, 0);
        check("rst_state", state, 0);
        check("rst_xfer", xfer_count, 0);
        check("rst_data", data_out, 0);
        check("rst_grant", grant_idx, 0);
        reset  = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("empty_state", state, 0);
            check("empty_pop", pop, 0);
            check("empty_push", push, 0);
        end

        // FIFOs 0, 3, 7 with two words each.
        fq[0].push_back(6'h11); fq[0].push_back(6'h12);
        fq[3].push_back(6'h31); fq[3].push_back(6'h32);
        fq[7].push_back(6'h3E); fq[7].push_back(6'h3F);
        refresh();
        expect_push(0, 6'h11); expect_push(3, 6'h31); expect_push(7, 6'h3E);
        expect_push(0, 6'h12); expect_push(3, 6'h32); expect_push(7, 6'h3F);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_pop", pop, seq2[k]);
        end
        @(negedge clk);
        check("rr_pop_end", pop, 0);
        wait_idle(10);
        check("rr_xfer", xfer_count, 6);
        check("rr_sb_drained", exp_q.size(), 0);

        // Single FIFO 5: one pop every other cycle.
        fq[5].push_back(6'h25); fq[5].push_back(6'h26); fq[5].push_back(6'h27);
        refresh();
        expect_push(5, 6'h25); expect_push(5, 6'h26); expect_push(5, 6'h27);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("single_pop", pop, seq3[k]);
        end
        wait_idle(10);
        check("single_xfer", xfer_count, 9);
        check("single_sb_drained", exp_q.size(), 0);

        // Stall raised alongside a pop; round-robin order continues after release.
        fq[1].push_back(6'h0A); fq[1].push_back(6'h0B);
        fq[2].push_back(6'h14); fq[2].push_back(6'h15);
        fq[4].push_back(6'h2C); fq[4].push_back(6'h2D);
        refresh();
        expect_push(1, 6'h0A); expect_push(2, 6'h14); expect_push(4, 6'h2C);
        expect_push(1, 6'h0B); expect_push(2, 6'h15); expect_push(4, 6'h2D);
        @(negedge clk);
        check("stall_pop1", pop, 8'h02);
        @(negedge clk);
        check("stall_pop2", pop, 8'h04);
        afo = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("pause_pop", pop, 0);
            check("pause_state", state, 2);
            check("pause_push", push, (k == 0) ? 1 : 0);
        end
        afo = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("resume_pop", pop, seq4[k]);
        end
        @(negedge clk);
        check("resume_pop_end", pop, 0);
        wait_idle(10);
        check("stall_xfer", xfer_count, 15);
        check("stall_sb_drained", exp_q.size(), 0);

        // Enable dropped with a pop in flight.
        fq[0].push_back(6'h01); fq[0].push_back(6'h02);
        fq[6].push_back(6'h1C); fq[6].push_back(6'h1D);
        refresh();
        expect_push(6, 6'h1C);
        @(negedge clk);
        check("dis_pop", pop, 8'h40);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pop_off", pop, 0);
        check("dis_state", state, 0);
        check("dis_push", push, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("dis_quiet_pop", pop, 0);
            check("dis_quiet_push", push, 0);
            check("dis_quiet_state", state, 0);
        end
        fq[0].delete();
        fq[6].delete();
        refresh();
        enable = 1'b1;
        check("dis_xfer", xfer_count, 16);
        check("dis_sb_drained", exp_q.size(), 0);

        // Fresh reset, then 256 transfers from FIFO 2 to wrap the counter.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 256; k++) begin
            fq[2].push_back(6'(k));
            expect_push(2, 6'(k));
        end
        refresh();
        @(negedge clk);
        check("wrap_run", state, 1);
        wait_idle(700);
        check("wrap_xfer", xfer_count, 0);
        check("wrap_sb_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stream.
        for (int k = 1; k <= 4; k++) begin
            fq[3].push_back(6'(8'h30 + k));
            fq[4].push_back(6'(8'h20 + k));
            expect_push(3, 6'(8'h30 + k));
            expect_push(4, 6'(8'h20 + k));
        end
        refresh();
        @(negedge clk);
        check("mid_pop1", pop, 8'h08);
        @(negedge clk);
        check("mid_pop2", pop, 8'h10);
        @(negedge clk);
        check("mid_pop3", pop, 8'h08);
        #2;
        reset = 1'b0;
        #1;
        check("arst_pop", pop, 0);
        check("arst_push", push, 0);
        check("arst_state", state, 0);
        check("arst_xfer", xfer_count, 0);
        check("arst_data", data_out, 0);
        check("arst_grant", grant_idx, 0);
        exp_q.delete();
        @(negedge clk);
        check("arst_hold_pop", pop, 0);
        check("arst_hold_push", push, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
